// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC sequencer: FSM states,
// pipeline latencies and default widths.
package conv_pkg;

  localparam int DEF_INW  = 16;
  localparam int DEF_OUTW = 64;
  localparam int DEF_DIMW = 8;
  localparam int DEF_AW   = 16;

  // Cycles between the last issue and a stable accumulator, and memory read latency.
  localparam int DRAIN_CYCLES = 3;
  localparam int MEM_RD_LAT   = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4,
    FINISH = 3'd5
  } state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// Output-pixel (r,c) and kernel-tap (i,j) counters with image/kernel/output
// address arithmetic; reports config legality and last-tap/last-pixel flags.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int DIMW = DEF_DIMW,
  parameter int AW   = DEF_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [DIMW-1:0] n_dim_i,
  input  logic [DIMW-1:0] m_dim_i,
  input  logic            clr_taps_i,
  input  logic            step_tap_i,
  input  logic            step_pix_i,
  output logic            cfg_err_o,
  output logic            last_tap_o,
  output logic            last_pix_o,
  output logic [AW-1:0]   x_addr_o,
  output logic [AW-1:0]   w_addr_o,
  output logic [AW-1:0]   out_addr_o
);

  logic [DIMW-1:0] n_q, n_d, m_q, m_d;
  logic [DIMW-1:0] r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d;
  logic [DIMW-1:0] span;
  logic [63:0]     n_sq;

  assign n_sq      = 64'(n_dim_i) * 64'(n_dim_i);
  assign cfg_err_o = (n_dim_i == '0) || (m_dim_i == '0) || (m_dim_i > n_dim_i) ||
                     (n_sq > (64'd1 << AW));

  assign span       = n_q - m_q;
  assign last_tap_o = (i_q == m_q - DIMW'(1)) && (j_q == m_q - DIMW'(1));
  assign last_pix_o = (r_q == span) && (c_q == span);

  // Products wrap at AW bits; legality of N*N is screened at start.
  assign x_addr_o   = (AW'(r_q) + AW'(i_q)) * AW'(n_q) + AW'(c_q) + AW'(j_q);
  assign w_addr_o   = AW'(i_q) * AW'(m_q) + AW'(j_q);
  assign out_addr_o = AW'(r_q) * (AW'(span) + AW'(1)) + AW'(c_q);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    n_d = n_q;
    m_d = m_q;
    r_d = r_q;
    c_d = c_q;
    i_d = i_q;
    j_d = j_q;
    if (load_i) begin
      n_d = n_dim_i;
      m_d = m_dim_i;
      r_d = '0;
      c_d = '0;
      i_d = '0;
      j_d = '0;
    end else begin
      if (clr_taps_i) begin
        i_d = '0;
        j_d = '0;
      end else if (step_tap_i) begin
        if (j_q == m_q - DIMW'(1)) begin
          j_d = '0;
          i_d = i_q + DIMW'(1);
        end else begin
          j_d = j_q + DIMW'(1);
        end
      end
      if (step_pix_i) begin
        if (c_q == span) begin
          c_d = '0;
          r_d = r_q + DIMW'(1);
        end else begin
          c_d = c_q + DIMW'(1);
        end
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q <= '0;
      m_q <= '0;
      r_q <= '0;
      c_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      n_q <= n_d;
      m_q <= m_d;
      r_q <= r_d;
      c_q <= c_d;
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/conv_mac_ctrl.sv
// Sequences a shared 2-stage pipelined MAC through a valid 2D convolution,
// emitting each finished pixel on a valid/ready stream.
module conv_mac_ctrl
  import conv_pkg::*;
#(
  parameter int INW  = DEF_INW,
  parameter int OUTW = DEF_OUTW,
  parameter int DIMW = DEF_DIMW,
  parameter int AW   = DEF_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DIMW-1:0] n_dim,
  input  logic [DIMW-1:0] m_dim,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [AW-1:0]   x_addr,
  output logic [AW-1:0]   w_addr,
  output logic            mem_re,
  output logic            mac_init_acc,
  output logic            mac_input_valid,
  input  logic [OUTW-1:0] mac_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUTW-1:0] out_data,
  output logic [AW-1:0]   out_addr
);

  if (OUTW < 2 * INW) begin : g_width_check
    $error("conv_mac_ctrl: OUTW cannot hold a full INW x INW product");
  end

  state_e                state_q, state_d;
  logic [1:0]            drain_q, drain_d;
  logic                  err_q, err_d;
  logic [OUTW-1:0]       out_data_q, out_data_d;
  logic [AW-1:0]         out_addr_q, out_addr_d;
  logic [MEM_RD_LAT-1:0] re_pipe_q;

  logic          load, clr_taps, step_tap, step_pix;
  logic          cfg_err, last_tap, last_pix;
  logic [AW-1:0] gen_out_addr;

  conv_addr_gen #(.DIMW(DIMW), .AW(AW)) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .n_dim_i    (n_dim),
    .m_dim_i    (m_dim),
    .clr_taps_i (clr_taps),
    .step_tap_i (step_tap),
    .step_pix_i (step_pix),
    .cfg_err_o  (cfg_err),
    .last_tap_o (last_tap),
    .last_pix_o (last_pix),
    .x_addr_o   (x_addr),
    .w_addr_o   (w_addr),
    .out_addr_o (gen_out_addr)
  );

  assign busy            = (state_q != IDLE) && (state_q != FINISH);
  assign done            = (state_q == FINISH);
  assign err             = done && err_q;
  assign mem_re          = (state_q == ISSUE);
  assign mac_init_acc    = (state_q == INIT);
  assign mac_input_valid = re_pipe_q[MEM_RD_LAT-1];
  assign out_valid       = (state_q == OUTPUT);
  assign out_data        = out_data_q;
  assign out_addr        = out_addr_q;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    err_d      = err_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    load       = 1'b0;
    clr_taps   = 1'b0;
    step_tap   = 1'b0;
    step_pix   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        err_d   = cfg_err;
        state_d = cfg_err ? FINISH : INIT;
      end
      INIT: begin
        clr_taps = 1'b1;
        state_d  = ISSUE;
      end
      ISSUE: begin
        step_tap = 1'b1;
        if (last_tap) begin
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      // mac_out is final in the last drain cycle; capture it with its index.
      DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          out_data_d = mac_out;
          out_addr_d = gen_out_addr;
          state_d    = OUTPUT;
        end
      end
      OUTPUT: if (out_ready) begin
        step_pix = 1'b1;
        state_d  = last_pix ? FINISH : INIT;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      err_q      <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      re_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      re_pipe_q  <= MEM_RD_LAT'({re_pipe_q, mem_re});
    end
  end

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Scoreboard bench for conv_mac_ctrl with behavioural memories and a
// 2-stage MAC model; directed vectors with hand-computed pixels.
module tb_conv_mac_ctrl;

  localparam int INW  = 16;
  localparam int OUTW = 64;
  localparam int DIMW = 8;
  localparam int AW   = 16;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [OUTW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [DIMW-1:0] n_dim = '0;
  logic [DIMW-1:0] m_dim = '0;
  logic            busy, done, err, mem_re, mac_init_acc, mac_input_valid, out_valid;
  logic [AW-1:0]   x_addr, w_addr, out_addr;
  logic [OUTW-1:0] mac_out, out_data;
  logic            out_ready = 1'b1;

  conv_mac_ctrl #(.INW(INW), .OUTW(OUTW), .DIMW(DIMW), .AW(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .n_dim           (n_dim),
    .m_dim           (m_dim),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .x_addr          (x_addr),
    .w_addr          (w_addr),
    .mem_re          (mem_re),
    .mac_init_acc    (mac_init_acc),
    .mac_input_valid (mac_input_valid),
    .mac_out         (mac_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_addr        (out_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories and MAC: read in t, input_valid in t+1, accumulate at end of t+2.
  logic signed [INW-1:0]    xmem [256];
  logic signed [INW-1:0]    wmem [256];
  logic signed [INW-1:0]    xr, wr;
  logic signed [2*INW-1:0]  prod;
  logic                     pv;
  logic signed [OUTW-1:0]   acc;

  always @(posedge clk) begin
    if (reset) begin
      xr <= '0; wr <= '0; prod <= '0; pv <= 1'b0; acc <= '0;
    end else begin
      if (mem_re) begin
        xr <= xmem[x_addr[7:0]];
        wr <= wmem[w_addr[7:0]];
      end
      prod <= xr * wr;
      pv   <= mac_input_valid;
      if (mac_init_acc) acc <= '0;
      else if (pv)      acc <= acc + OUTW'(prod);
    end
  end
  assign mac_out = acc;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   mem_re_cnt = 0;
  int   first_valid_cyc = -1;
  int   start_cyc = 0;
  int   done_cyc = 0;
  bit   stall_en = 1'b0;
  logic [AW-1:0]   stall_addr = '0;
  logic [OUTW-1:0] stall_data = '0;

  task automatic check(input string name, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int a, input longint d);
    exp_t e;
    e.addr = AW'(a);
    e.data = OUTW'(d);
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial forever begin
    @(negedge clk);
    if (mem_re) mem_re_cnt++;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got addr %0d data %0d with nothing expected", out_addr, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pixel_addr", out_addr, e.addr);
        check("pixel_data", out_data, e.data);
      end
    end
  end

  // Backpressure: hold out_ready low for 10 cycles on the chosen pixel.
  initial forever begin
    @(posedge clk); #1;
    if (stall_en && out_valid && out_addr == stall_addr) begin
      stall_en  = 1'b0;
      out_ready = 1'b0;
      repeat (10) begin
        @(posedge clk); #1;
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, stall_data);
        check("stall_no_mem_re", mem_re, 0);
      end
      out_ready = 1'b1;
    end
  end

  task automatic run_conv(input int n, input int m, input logic exp_err, input bit extra_start);
    bit seen;
    @(posedge clk); #1;
    mem_re_cnt      = 0;
    first_valid_cyc = -1;
    n_dim           = DIMW'(n);
    m_dim           = DIMW'(m);
    start           = 1'b1;
    start_cyc       = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (extra_start) begin
      repeat (2) @(posedge clk);
      #1;
      n_dim = 8'd3;
      m_dim = 8'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_before_timeout", seen, 1);
    done_cyc = cyc;
    check("err_with_done", err, exp_err);
    check("busy_low_at_done", busy, 0);
    check("scoreboard_drained", sb.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic load_image_1_to_9();
    for (int k = 0; k < 9; k++) begin
      xmem[k] = INW'(k + 1);
      wmem[k] = 16'sd1;
    end
  endtask

  initial begin
    bit hit;
    for (int k = 0; k < 256; k++) begin
      xmem[k] = '0;
      wmem[k] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_mem_re", mem_re, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_input_valid", mac_input_valid, 0);
    reset = 1'b0;

    // N=3, M=2, image 1..9, kernel of ones.
    load_image_1_to_9();
    push_exp(0, 12); push_exp(1, 16); push_exp(2, 24); push_exp(3, 28);
    run_conv(3, 2, 1'b0, 1'b0);
    check("first_valid_latency_m2", first_valid_cyc - start_cyc, 9);
    check("mem_re_cycles_3x2", mem_re_cnt, 16);

    // Same config with 10 cycles of backpressure on pixel 1.
    stall_en   = 1'b1;
    stall_addr = AW'(1);
    stall_data = OUTW'(16);
    push_exp(0, 12); push_exp(1, 16); push_exp(2, 24); push_exp(3, 28);
    run_conv(3, 2, 1'b0, 1'b0);
    check("mem_re_cycles_stalled", mem_re_cnt, 16);
    check("stall_released", stall_en, 0);

    // N=M=2, signed kernel, with a start issued mid-run that must be ignored.
    xmem[0] = 16'sd1; xmem[1] = 16'sd2; xmem[2] = 16'sd3; xmem[3] = 16'sd4;
    wmem[0] = 16'sd1; wmem[1] = -16'sd1; wmem[2] = 16'sd2; wmem[3] = 16'sd0;
    push_exp(0, 5);
    run_conv(2, 2, 1'b0, 1'b1);
    check("mem_re_cycles_2x2", mem_re_cnt, 4);
    repeat (20) @(negedge clk);
    check("ignored_start_idle", busy, 0);

    // M=1: one tap per pixel, drain unchanged.
    wmem[0] = 16'sd3;
    push_exp(0, 3); push_exp(1, 6); push_exp(2, 9); push_exp(3, 12);
    run_conv(2, 1, 1'b0, 1'b0);
    check("first_valid_latency_m1", first_valid_cyc - start_cyc, 6);
    check("mem_re_cycles_2x1", mem_re_cnt, 4);

    // Illegal configurations.
    run_conv(3, 4, 1'b1, 1'b0);
    check("err_done_latency", done_cyc - start_cyc, 1);
    check("err_no_mem_re", mem_re_cnt, 0);
    run_conv(3, 0, 1'b1, 1'b0);
    check("err_m0_no_mem_re", mem_re_cnt, 0);

    // Reset in the middle of ISSUE aborts without a done pulse.
    load_image_1_to_9();
    @(posedge clk); #1;
    n_dim = 8'd3;
    m_dim = 8'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(posedge clk); #1;
      if (mem_re) hit = 1'b1;
    end
    check("issue_reached", hit, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_mem_re", mem_re, 0);
    check("abort_init_acc", mac_init_acc, 0);
    check("abort_input_valid", mac_input_valid, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_x_addr", x_addr, 0);
    check("abort_w_addr", w_addr, 0);
    reset = 1'b0;
    push_exp(0, 12); push_exp(1, 16); push_exp(2, 24); push_exp(3, 28);
    run_conv(3, 2, 1'b0, 1'b0);
    check("rerun_latency", first_valid_cyc - start_cyc, 9);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
